// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns a field set (op, rd, rs1, rs2, imm) into an RV32I instruction word and
//   buffers it in a 2-entry FIFO. Each word carries a byte address. The address
//   starts at ADDR_BASE and advances by 4 on every output handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush; has priority over both handshakes
//   in_valid   field set valid            in_ready   FIFO not full
//   op         0 ADD,1 SUB,2 AND,3 OR,4 ADDI,5 LW,6 SW,7 BEQ; 8-15 illegal
//   rd/rs1/rs2 register indices           imm        13-bit signed immediate
//   out_valid  FIFO not empty             out_ready  consumer accepts head
//   out_instr  head instruction word      out_addr   byte address of head
//   err        sticky illegal-input flag  count      FIFO occupancy (0..2)
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [1:0]  count
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7
    } op_e;

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count_q;
    logic [31:0] addr_q;
    logic        err_q;

    logic [31:0] enc;
    logic        illegal;
    logic        in_fire;
    logic        out_fire;
    logic        push;
    logic        pop;

    // Flow control depends on registered occupancy only.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != 2'd0);
    assign out_instr = mem[rd_ptr];
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign count     = count_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign push     = in_fire & ~illegal & ~clear;
    assign pop      = out_fire & ~clear;

    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        case (op_e'(op))
            OP_ADD:  enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_SUB:  enc = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_AND:  enc = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            OP_OR:   enc = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            OP_ADDI: enc = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            OP_LW:   enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            OP_SW:   enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_BEQ: begin
                enc     = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                           imm[4:1], imm[11], 7'b1100011};
                // Branch offsets must be even; bit 0 is not encodable.
                illegal = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Data storage is deliberately left unreset; out_instr is only meaningful
    // while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= '0;
            addr_q  <= ADDR_BASE;
            err_q   <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= '0;
            addr_q  <= ADDR_BASE;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                addr_q <= addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (in_fire && illegal) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. Expected words are queued when a set is
//   accepted and compared at the output handshake. A second instance with a
//   base address near the top of the address space shares all inputs and is
//   used to observe address wrap.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        out_ready;

    logic        in_ready,  w_in_ready;
    logic        out_valid, w_out_valid;
    logic [31:0] out_instr, w_out_instr;
    logic [31:0] out_addr,  w_out_addr;
    logic        err,       w_err;
    logic [1:0]  count,     w_count;

    instr_encoder #(.ADDR_BASE(BASE), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .count(count)
    );

    instr_encoder #(.ADDR_BASE(WRAP_BASE), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_instr(w_out_instr), .out_addr(w_out_addr),
        .err(w_err), .count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q [$];
    logic [31:0] exp_addr;
    logic [31:0] exp_addr2;
    logic        exp_err;
    logic [31:0] cur_exp;
    bit          cur_legal;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [12:0] im,
                          input logic [31:0] e, input bit lg);
        in_valid  = 1'b1;
        op        = o;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        imm       = im;
        cur_exp   = e;
        cur_legal = lg;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance
    // the model across the rising edge.
    task automatic cycle();
        bit fin;
        bit fout;
        @(negedge clk);
        chk("count",      32'(count),       32'(q.size()));
        chk("wrap_count", 32'(w_count),     32'(q.size()));
        chk("out_valid",  32'(out_valid),   32'(q.size() != 0));
        chk("in_ready",   32'(in_ready),    32'(q.size() != 2));
        chk("err",        32'(err),         32'(exp_err));
        chk("out_addr",   out_addr,         exp_addr);
        chk("wrap_addr",  w_out_addr,       exp_addr2);
        if (q.size() != 0) begin
            chk("out_instr", out_instr, q[0]);
        end
        fin  = in_valid && (q.size() < 2);
        fout = out_ready && (q.size() != 0);
        @(posedge clk);
        if (clear) begin
            q.delete();
            exp_addr  = BASE;
            exp_addr2 = WRAP_BASE;
            exp_err   = 1'b0;
        end else begin
            if (fout) begin
                void'(q.pop_front());
                exp_addr  = exp_addr + 32'd4;
                exp_addr2 = exp_addr2 + 32'd4;
            end
            if (fin) begin
                if (cur_legal) q.push_back(cur_exp);
                else           exp_err = 1'b1;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must respond before
    // any clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_out_addr",  out_addr,       BASE);
        chk("rst_wrap_addr", w_out_addr,     WRAP_BASE);
        q.delete();
        exp_addr  = BASE;
        exp_addr2 = WRAP_BASE;
        exp_err   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        cur_exp = '0; cur_legal = 1'b0;
        exp_addr = BASE; exp_addr2 = WRAP_BASE; exp_err = 1'b0;
        #1;
        do_reset();

        // R-type, first handshake on the first edge after reset release
        out_ready = 1'b1;
        set_in(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
        cycle();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_instr", out_instr, 32'h002081B3);
        chk("lat_addr",  out_addr,  32'h0000_0000);
        set_in(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 32'h407302B3, 1'b1);
        cycle();
        chk("sub_addr",  out_addr,  32'h0000_0004);
        chk("sub_instr", out_instr, 32'h407302B3);

        // Immediate forms back to back (push and pop together at count 1)
        set_in(4'd4, 5'd1, 5'd0, 5'd0, 13'h1FFF, 32'hFFF00093, 1'b1);
        cycle();
        set_in(4'd5, 5'd2, 5'd1, 5'd0, 13'd8,    32'h0080A103, 1'b1);
        cycle();
        set_in(4'd6, 5'd0, 5'd1, 5'd2, 13'd12,   32'h0020A623, 1'b1);
        cycle();
        set_in(4'd7, 5'd0, 5'd1, 5'd2, 13'h1FFC, 32'hFE208EE3, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Backpressure: three sets offered, only two fit
        do_reset();
        out_ready = 1'b0;
        set_in(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
        cycle();
        set_in(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 32'h407302B3, 1'b1);
        cycle();
        set_in(4'd2, 5'd4, 5'd5, 5'd6, 13'd0, 32'h0062F233, 1'b1);
        cycle();
        chk("bp_count",    32'(count),    32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("bp_end_addr", out_addr, 32'h0000_000C);
        cycle();

        // Illegal inputs, then a legal word at the next address
        set_in(4'd9, 5'd1, 5'd1, 5'd1, 13'd0, 32'h0, 1'b0);
        cycle();
        chk("ill_err",   32'(err),       32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        set_in(4'd7, 5'd0, 5'd1, 5'd2, 13'd3, 32'h0, 1'b0);
        cycle();
        chk("beq_odd_err", 32'(err), 32'd1);
        set_in(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
        cycle();
        chk("ill_next_addr",  out_addr,  32'h0000_000C);
        chk("ill_next_instr", out_instr, 32'h002081B3);
        in_valid = 1'b0;
        cycle();

        // Clear while full with err set, alongside an offered set
        out_ready = 1'b0;
        set_in(4'd2, 5'd4, 5'd5, 5'd6, 13'd0, 32'h0062F233, 1'b1);
        cycle();
        set_in(4'd3, 5'd7, 5'd8, 5'd9, 13'd0, 32'h009463B3, 1'b1);
        cycle();
        chk("clr_pre_count", 32'(count), 32'd2);
        clear = 1'b1;
        set_in(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_err",   32'(err),   32'd0);
        chk("clr_addr",  out_addr,   BASE);
        cycle();

        // Clear at count 1 must also drop the accepted set
        set_in(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
        cycle();
        clear = 1'b1;
        set_in(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 32'h407302B3, 1'b1);
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr1_count", 32'(count), 32'd0);
        cycle();

        // Mid-stream reset discards buffered words
        set_in(4'd2, 5'd4, 5'd5, 5'd6, 13'd0, 32'h0062F233, 1'b1);
        cycle();
        set_in(4'd3, 5'd7, 5'd8, 5'd9, 13'd0, 32'h009463B3, 1'b1);
        cycle();
        do_reset();

        // Address wrap on the high-base instance
        out_ready = 1'b1;
        set_in(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
        cycle();
        chk("wrap_first", w_out_addr, 32'hFFFF_FFFC);
        set_in(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 32'h407302B3, 1'b1);
        cycle();
        chk("wrap_second",       w_out_addr,         32'h0000_0000);
        chk("wrap_second_valid", 32'(w_out_valid),   32'd1);
        chk("wrap_second_instr", w_out_instr,        32'h407302B3);
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("final_count", 32'(count), 32'd0);
        chk("final_wrap_ready", 32'(w_in_ready), 32'd1);
        chk("final_wrap_err",   32'(w_err),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
